// File: rtl/ecc_point_unit_pkg.sv
// Shared types and GF(p) helpers for the elliptic-curve point unit.
// Arithmetic helpers work on 16-bit containers; callers zero-extend narrower operands.
package ecc_pkg;

  typedef enum logic [3:0] {
    S_IDLE     = 4'd0,
    S_CLASSIFY = 4'd1,
    S_NUM      = 4'd2,
    S_DEN      = 4'd3,
    S_INV      = 4'd4,
    S_SLOPE    = 4'd5,
    S_RX       = 4'd6,
    S_RY       = 4'd7,
    S_INF      = 4'd8,
    S_DONE     = 4'd9
  } state_t;

  // Worst-case cycles from request acceptance to the result strobe.
  function automatic int LAT_MAX(input int w);
    return (2 * w + 5) * (w + 1) + 8;
  endfunction

  function automatic logic [15:0] modadd(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] p);
    logic [16:0] sum;
    sum = {1'b0, x} + {1'b0, y};
    if (sum >= {1'b0, p}) sum = sum - {1'b0, p};
    return sum[15:0];
  endfunction

  function automatic logic [15:0] modsub(input logic [15:0] x, input logic [15:0] y,
                                         input logic [15:0] p);
    if (x >= y) return x - y;
    return x + (p - y);
  endfunction

endpackage

// File: rtl/ecc_point_unit_if.sv
// Request/result bundle between the host and the point unit.
// ECC_NEG_EN adds the in_sub operand that selects P - Q.
interface ecc_point_unit_if #(parameter int W = 6);
  logic         in_valid;
  logic [W-1:0] in_Px;
  logic [W-1:0] in_Py;
  logic [W-1:0] in_Qx;
  logic [W-1:0] in_Qy;
  logic [W-1:0] in_prime;
  logic [W-1:0] in_a;
`ifdef ECC_NEG_EN
  logic         in_sub;
`endif
  logic         out_valid;
  logic [W-1:0] out_Rx;
  logic [W-1:0] out_Ry;
  logic         out_inf;
  logic         out_busy;

`ifdef ECC_NEG_EN
  modport master (output in_valid, in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a, in_sub,
                  input  out_valid, out_Rx, out_Ry, out_inf, out_busy);
  modport slave  (input  in_valid, in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a, in_sub,
                  output out_valid, out_Rx, out_Ry, out_inf, out_busy);
`else
  modport master (output in_valid, in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a,
                  input  out_valid, out_Rx, out_Ry, out_inf, out_busy);
  modport slave  (input  in_valid, in_Px, in_Py, in_Qx, in_Qy, in_prime, in_a,
                  output out_valid, out_Rx, out_Ry, out_inf, out_busy);
`endif
endinterface

// File: rtl/ecc_point_unit_modmul.sv
// Interleaved MSB-first shift-add modular multiplier: y = a*b mod p.
// One multiplier bit per cycle; done pulses W+1 cycles after start.
module ecc_modmul #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] p,
  output logic         done,
  output logic [W-1:0] y
);
  localparam int CW = $clog2(W + 1);

  logic [W-1:0]  a_r, b_r, p_r, acc;
  logic [CW-1:0] cnt;
  logic          run;
  logic [W:0]    dbl, sum;
  logic [W-1:0]  dbl_red, step;

  // acc stays reduced, so 2*acc and acc+a both fit in W+1 bits and need one subtraction.
  always_comb begin
    dbl     = {acc, 1'b0};
    dbl_red = (dbl >= {1'b0, p_r}) ? W'(dbl - {1'b0, p_r}) : dbl[W-1:0];
    sum     = {1'b0, dbl_red} + {1'b0, ({W{b_r[W-1]}} & a_r)};
    step    = (sum >= {1'b0, p_r}) ? W'(sum - {1'b0, p_r}) : sum[W-1:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_r  <= '0;
      b_r  <= '0;
      p_r  <= '0;
      acc  <= '0;
      cnt  <= '0;
      run  <= 1'b0;
      done <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        a_r <= a;
        b_r <= b;
        p_r <= p;
        acc <= '0;
        cnt <= CW'(W);
        run <= 1'b1;
      end else if (run) begin
        acc <= step;
        b_r <= {b_r[W-2:0], 1'b0};
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          run  <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

  assign y = acc;

endmodule

// File: rtl/ecc_point_unit.sv
// Elliptic-curve point add/double over GF(p) with Fermat inversion.
// Optional ECC_NEG_EN: in_sub=1 negates Q at acceptance so the unit returns P - Q.
module ecc_point_unit
  import ecc_pkg::*;
#(
  parameter int W = 6
) (
  input logic             clk,
  input logic             rst,
  ecc_point_unit_if.slave bus
);
  localparam int IW = $clog2(W);

  state_t        state, next_state;
  logic [W-1:0]  px, py, qx, qy, prime, a_coef, exp_bits;
  logic [W-1:0]  num, den, inv, s, rx, ry;
  logic          dbl, is_inf, pend, inv_mul;
  logic [IW-1:0] bit_idx;
  logic          accept, mul_start, mul_done, inv_bit_done, inf_case;
  logic [W-1:0]  mul_a, mul_b, mul_y;

  function automatic logic [W-1:0] add_p(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] m);
    return W'(modadd(16'(x), 16'(y), 16'(m)));
  endfunction

  function automatic logic [W-1:0] sub_p(input logic [W-1:0] x, input logic [W-1:0] y,
                                         input logic [W-1:0] m);
    return W'(modsub(16'(x), 16'(y), 16'(m)));
  endfunction

  ecc_modmul #(.W(W)) u_mul (
    .clk   (clk),
    .rst   (rst),
    .start (mul_start),
    .a     (mul_a),
    .b     (mul_b),
    .p     (prime),
    .done  (mul_done),
    .y     (mul_y)
  );

  assign accept       = bus.in_valid && (state == S_IDLE || state == S_DONE);
  assign inf_case     = (px == qx) && (py != qy || py == '0);
  assign inv_bit_done = mul_done && (inv_mul || !exp_bits[bit_idx]);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= next_state;
  end

  // Each multiply state issues one start (guarded by pend) and advances on done.
  always_comb begin
    next_state = state;
    mul_start  = 1'b0;
    mul_a      = '0;
    mul_b      = '0;
    case (state)
      S_IDLE:     if (accept) next_state = S_CLASSIFY;
      S_CLASSIFY: next_state = inf_case ? S_INF : S_NUM;
      S_NUM: begin
        if (dbl) begin
          mul_a     = px;
          mul_b     = px;
          mul_start = !pend;
          if (mul_done) next_state = S_DEN;
        end else begin
          next_state = S_DEN;
        end
      end
      S_DEN: next_state = S_INV;
      S_INV: begin
        mul_a     = inv;
        mul_b     = inv_mul ? den : inv;
        mul_start = !pend;
        if (inv_bit_done && bit_idx == '0) next_state = S_SLOPE;
      end
      S_SLOPE: begin
        mul_a     = num;
        mul_b     = inv;
        mul_start = !pend;
        if (mul_done) next_state = S_RX;
      end
      S_RX: begin
        mul_a     = s;
        mul_b     = s;
        mul_start = !pend;
        if (mul_done) next_state = S_RY;
      end
      S_RY: begin
        mul_a     = s;
        mul_b     = sub_p(px, rx, prime);
        mul_start = !pend;
        if (mul_done) next_state = S_DONE;
      end
      S_INF:  next_state = S_DONE;
      S_DONE: next_state = accept ? S_CLASSIFY : S_IDLE;
      default: next_state = S_IDLE;
    endcase
  end

  // Inverse walks p-2 MSB first: square every bit, extra multiply by den on a one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      px       <= '0;
      py       <= '0;
      qx       <= '0;
      qy       <= '0;
      prime    <= '0;
      a_coef   <= '0;
      exp_bits <= '0;
      num      <= '0;
      den      <= '0;
      inv      <= '0;
      s        <= '0;
      rx       <= '0;
      ry       <= '0;
      dbl      <= 1'b0;
      is_inf   <= 1'b0;
      pend     <= 1'b0;
      inv_mul  <= 1'b0;
      bit_idx  <= '0;
    end else begin
      if (mul_start)     pend <= 1'b1;
      else if (mul_done) pend <= 1'b0;

      if (accept) begin
        px       <= bus.in_Px;
        py       <= bus.in_Py;
        qx       <= bus.in_Qx;
        prime    <= bus.in_prime;
        a_coef   <= bus.in_a;
        exp_bits <= bus.in_prime - W'(2);
`ifdef ECC_NEG_EN
        qy <= (bus.in_sub && bus.in_Qy != '0) ? bus.in_prime - bus.in_Qy : bus.in_Qy;
`else
        qy <= bus.in_Qy;
`endif
      end

      case (state)
        S_CLASSIFY: begin
          dbl     <= (px == qx);
          is_inf  <= inf_case;
          inv     <= W'(1);
          inv_mul <= 1'b0;
          bit_idx <= IW'(W - 1);
        end
        S_NUM: begin
          if (!dbl)
            num <= sub_p(qy, py, prime);
          else if (mul_done)
            num <= add_p(add_p(add_p(mul_y, mul_y, prime), mul_y, prime), a_coef, prime);
        end
        S_DEN: den <= dbl ? add_p(py, py, prime) : sub_p(qx, px, prime);
        S_INV: begin
          if (mul_done) begin
            inv <= mul_y;
            if (!inv_mul && exp_bits[bit_idx]) begin
              inv_mul <= 1'b1;
            end else begin
              inv_mul <= 1'b0;
              bit_idx <= bit_idx - 1'b1;
            end
          end
        end
        S_SLOPE: if (mul_done) s <= mul_y;
        S_RX:    if (mul_done) rx <= sub_p(sub_p(mul_y, px, prime), qx, prime);
        S_RY:    if (mul_done) ry <= sub_p(mul_y, py, prime);
        default: ;
      endcase
    end
  end

  assign bus.out_valid = (state == S_DONE);
  assign bus.out_inf   = (state == S_DONE) && is_inf;
  assign bus.out_Rx    = (state == S_DONE && !is_inf) ? rx : '0;
  assign bus.out_Ry    = (state == S_DONE && !is_inf) ? ry : '0;
  assign bus.out_busy  = (state != S_IDLE) && (state != S_DONE);

endmodule

// File: tb/tb_ecc_point_unit.sv
// Bench for ecc_point_unit: W=6 directed vectors on p=11 and W=8 model-checked vectors on p=251.
// Under ECC_NEG_EN it also exercises the in_sub path.
module tb_ecc_point_unit;

  typedef struct {
    int rx;
    int ry;
    bit inf;
    int t;
  } exp_t;

  logic clk;
  logic rst;
  int   cyc;
  int   total;
  int   bad;
  exp_t q6[$];
  exp_t q8[$];

  ecc_point_unit_if #(.W(6)) bus6 ();
  ecc_point_unit_if #(.W(8)) bus8 ();

  ecc_point_unit #(.W(6)) dut6 (.clk(clk), .rst(rst), .bus(bus6));
  ecc_point_unit #(.W(8)) dut8 (.clk(clk), .rst(rst), .bus(bus8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    total++;
    if (actual != expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic check_le(input string name, input int actual, input int limit);
    total++;
    if (actual > limit) begin
      bad++;
      $display("[TB] FAIL %s: got %0d, expected at most %0d", name, actual, limit);
    end
  endtask

  // Reference: brute-force inverse and textbook chord/tangent formulas.
  function automatic int inv_mod(input int d, input int p);
    for (int k = 1; k < p; k++)
      if ((d * k) % p == 1) return k;
    return 0;
  endfunction

  function automatic void ref_point(input int p, input int a, input int px, input int py,
                                    input int qx, input int qy,
                                    output int rx, output int ry, output bit inf);
    int sl;
    rx  = 0;
    ry  = 0;
    inf = 1'b0;
    if (px == qx && (py != qy || py == 0)) begin
      inf = 1'b1;
      return;
    end
    if (px == qx)
      sl = (((3 * px * px + a) % p) * inv_mod((2 * py) % p, p)) % p;
    else
      sl = (((qy - py + p) % p) * inv_mod((qx - px + p) % p, p)) % p;
    rx = ((sl * sl) % p + 2 * p - px - qx) % p;
    ry = ((sl * ((px - rx + p) % p)) % p + p - py) % p;
  endfunction

  task automatic apply_stimulus(input int w, input int px, input int py, input int qx,
                                input int qy, input int p, input int a, input bit sub,
                                input bit no_wait, input bit expect_it,
                                input int erx, input int ery, input bit einf);
    exp_t e;
    if (!no_wait) begin
      @(posedge clk);
      #1;
    end
    e.rx  = erx;
    e.ry  = ery;
    e.inf = einf;
    e.t   = cyc + 1;
    if (w == 6) begin
      bus6.in_valid = 1'b1;
      bus6.in_Px = 6'(px); bus6.in_Py = 6'(py); bus6.in_Qx = 6'(qx); bus6.in_Qy = 6'(qy);
      bus6.in_prime = 6'(p); bus6.in_a = 6'(a);
`ifdef ECC_NEG_EN
      bus6.in_sub = sub;
`endif
      if (expect_it) q6.push_back(e);
    end else begin
      bus8.in_valid = 1'b1;
      bus8.in_Px = 8'(px); bus8.in_Py = 8'(py); bus8.in_Qx = 8'(qx); bus8.in_Qy = 8'(qy);
      bus8.in_prime = 8'(p); bus8.in_a = 8'(a);
`ifdef ECC_NEG_EN
      bus8.in_sub = sub;
`endif
      if (expect_it) q8.push_back(e);
    end
    @(posedge clk);
    #1;
    bus6.in_valid = 1'b0;
    bus8.in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int w, input int bound);
    int left;
    left = (w == 6) ? q6.size() : q8.size();
    for (int i = 0; i < bound && left != 0; i++) begin
      @(posedge clk);
      left = (w == 6) ? q6.size() : q8.size();
    end
    check_output($sformatf("w%0d results outstanding after %0d cycles", w, bound), left, 0);
    if (w == 6) q6.delete();
    else        q8.delete();
  endtask

  // Every cycle: a strobe must match the next expected result, otherwise outputs read zero.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (bus6.out_valid) begin
        if (q6.size() == 0) begin
          check_output("w6 unexpected out_valid", 1, 0);
        end else begin
          e = q6.pop_front();
          check_output("w6 Rx", int'(bus6.out_Rx), e.rx);
          check_output("w6 Ry", int'(bus6.out_Ry), e.ry);
          check_output("w6 inf", int'(bus6.out_inf), int'(e.inf));
          check_le("w6 latency", cyc - e.t, 127);
        end
      end else begin
        check_output("w6 idle outputs", int'(bus6.out_Rx) + int'(bus6.out_Ry) + int'(bus6.out_inf), 0);
      end
      if (bus8.out_valid) begin
        if (q8.size() == 0) begin
          check_output("w8 unexpected out_valid", 1, 0);
        end else begin
          e = q8.pop_front();
          check_output("w8 Rx", int'(bus8.out_Rx), e.rx);
          check_output("w8 Ry", int'(bus8.out_Ry), e.ry);
          check_output("w8 inf", int'(bus8.out_inf), int'(e.inf));
          check_le("w8 latency", cyc - e.t, (2 * 8 + 5) * (8 + 1) + 8);
        end
      end else begin
        check_output("w8 idle outputs", int'(bus8.out_Rx) + int'(bus8.out_Ry) + int'(bus8.out_inf), 0);
      end
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int rx, ry, px, py, qx, qy, a, seen;
    bit inf;
    total = 0;
    bad   = 0;
    cyc   = 0;
    rst   = 1'b1;
    bus6.in_valid = 1'b0; bus6.in_Px = '0; bus6.in_Py = '0; bus6.in_Qx = '0;
    bus6.in_Qy = '0; bus6.in_prime = '0; bus6.in_a = '0;
    bus8.in_valid = 1'b0; bus8.in_Px = '0; bus8.in_Py = '0; bus8.in_Qx = '0;
    bus8.in_Qy = '0; bus8.in_prime = '0; bus8.in_a = '0;
`ifdef ECC_NEG_EN
    bus6.in_sub = 1'b0;
    bus8.in_sub = 1'b0;
`endif
    #12;
    check_output("reset w6 out_valid", int'(bus6.out_valid), 0);
    check_output("reset w6 out_busy", int'(bus6.out_busy), 0);
    check_output("reset w6 outputs", int'(bus6.out_Rx) + int'(bus6.out_Ry) + int'(bus6.out_inf), 0);
    check_output("reset w8 out_valid", int'(bus8.out_valid), 0);
    check_output("reset w8 out_busy", int'(bus8.out_busy), 0);
    @(negedge clk);
    rst = 1'b0;

    ref_point(11, 1, 2, 7, 3, 5, rx, ry, inf);
    check_output("model add Rx", rx, 10);
    check_output("model add Ry", ry, 9);
    ref_point(11, 1, 2, 7, 2, 7, rx, ry, inf);
    check_output("model dbl Rx", rx, 5);
    check_output("model dbl Ry", ry, 2);
    ref_point(11, 1, 2, 7, 2, 4, rx, ry, inf);
    check_output("model inf", int'(inf), 1);

    apply_stimulus(6, 2, 7, 3, 5, 11, 1, 1'b0, 1'b0, 1'b1, 10, 9, 1'b0);
    wait_drain(6, 200);
    apply_stimulus(6, 2, 7, 2, 7, 11, 1, 1'b0, 1'b0, 1'b1, 5, 2, 1'b0);
    wait_drain(6, 200);
    apply_stimulus(6, 2, 7, 2, 4, 11, 1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    wait_drain(6, 200);
    apply_stimulus(6, 5, 0, 5, 0, 11, 1, 1'b0, 1'b0, 1'b1, 0, 0, 1'b1);
    wait_drain(6, 200);

    // A second request while busy is dropped; only the first result may appear.
    apply_stimulus(6, 2, 7, 3, 5, 11, 1, 1'b0, 1'b0, 1'b1, 10, 9, 1'b0);
    repeat (10) @(posedge clk);
    #1;
    check_output("w6 busy during request", int'(bus6.out_busy), 1);
    apply_stimulus(6, 2, 7, 2, 7, 11, 1, 1'b0, 1'b1, 1'b0, 0, 0, 1'b0);
    wait_drain(6, 200);
    repeat (140) @(posedge clk);

    // Reset in the middle of the inversion aborts the request silently.
    apply_stimulus(6, 2, 7, 3, 5, 11, 1, 1'b0, 1'b0, 1'b1, 10, 9, 1'b0);
    repeat (20) @(posedge clk);
    #1;
    check_output("w6 busy before abort", int'(bus6.out_busy), 1);
    q6.delete();
    rst = 1'b1;
    #1;
    check_output("w6 busy after reset", int'(bus6.out_busy), 0);
    check_output("w6 valid after reset", int'(bus6.out_valid), 0);
    check_output("w6 outputs after reset", int'(bus6.out_Rx) + int'(bus6.out_Ry) + int'(bus6.out_inf), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(posedge clk);
    apply_stimulus(6, 2, 7, 2, 7, 11, 1, 1'b0, 1'b0, 1'b1, 5, 2, 1'b0);
    wait_drain(6, 200);

`ifdef ECC_NEG_EN
    apply_stimulus(6, 2, 7, 3, 6, 11, 1, 1'b1, 1'b0, 1'b1, 10, 9, 1'b0);
    wait_drain(6, 200);
`endif

    for (int i = 0; i < 5; i++) begin
      a  = $urandom_range(250, 0);
      px = $urandom_range(250, 0);
      py = $urandom_range(250, 1);
      ref_point(251, a, px, py, px, py, qx, qy, inf);
      apply_stimulus(8, px, py, px, py, 251, a, 1'b0, 1'b0, 1'b1, qx, qy, inf);
      wait_drain(8, 300);
      ref_point(251, a, px, py, qx, qy, rx, ry, inf);
      apply_stimulus(8, px, py, qx, qy, 251, a, 1'b0, 1'b0, 1'b1, rx, ry, inf);
      wait_drain(8, 300);
    end

    // Back-to-back: the next request is presented in the result cycle.
    a  = $urandom_range(250, 0);
    px = $urandom_range(250, 0);
    py = $urandom_range(250, 1);
    ref_point(251, a, px, py, px, py, qx, qy, inf);
    apply_stimulus(8, px, py, px, py, 251, a, 1'b0, 1'b0, 1'b1, qx, qy, inf);
    seen = 0;
    for (int i = 0; i < 300 && seen == 0; i++) begin
      @(posedge clk);
      #1;
      if (bus8.out_valid) seen = 1;
    end
    check_output("w8 first result strobe seen", seen, 1);
    ref_point(251, a, px, py, qx, qy, rx, ry, inf);
    apply_stimulus(8, px, py, qx, qy, 251, a, 1'b0, 1'b1, 1'b1, rx, ry, inf);
    wait_drain(8, 300);

    repeat (5) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
